// File: rtl/rrp_otf_conv_pkg.sv
// Shared types and width helpers for the rRp on-the-fly converter.
// Holds the FSM state encoding and the digit/result width functions.
package rrp_otf_conv_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } otf_state_e;

    // Bits per radix digit
    function automatic int otf_k(input int radix);
        return $clog2(radix);
    endfunction

    // Signed digit width
    function automatic int otf_d(input int radix);
        return $clog2(radix) + 1;
    endfunction

    // Signed result width
    function automatic int otf_ow(input int radix, input int ndig);
        return $clog2(radix) * ndig + 1;
    endfunction

endpackage

// File: rtl/rrp_otf_conv_step.sv
// One combinational on-the-fly conversion step: (Q, QM, d) -> (Q', QM').
// Ports: i_q/i_qm current registers, i_d signed digit,
//        o_q/o_qm next registers, o_illegal digit was the -RADIX code.
module rrp_otf_conv_step
    import rrp_otf_conv_pkg::*;
#(
    parameter int  RADIX = 4,
    parameter int  NDIG  = 7,
    localparam int K     = otf_k(RADIX),
    localparam int D     = otf_d(RADIX),
    localparam int OW    = otf_ow(RADIX, NDIG)
) (
    input  logic [OW-1:0] i_q,
    input  logic [OW-1:0] i_qm,
    input  logic [D-1:0]  i_d,
    output logic [OW-1:0] o_q,
    output logic [OW-1:0] o_qm,
    output logic          o_illegal
);

    logic [K-1:0]    w_b;
    logic [K-1:0]    w_bm1;
    logic [OW-K-1:0] w_q_sh;
    logic [OW-K-1:0] w_qm_sh;
    logic            w_neg;
    logic            w_zero;

    assign w_b     = i_d[K-1:0];
    assign w_bm1   = w_b - K'(1);
    assign w_q_sh  = i_q[OW-K-1:0];
    assign w_qm_sh = i_qm[OW-K-1:0];
    assign w_neg   = i_d[K];
    assign w_zero  = (i_d == '0);

    // The -RADIX code has b=0 and is folded through the d<0 path.
    assign o_illegal = (i_d == {1'b1, {K{1'b0}}});

    always_comb begin
        o_q  = {w_q_sh, w_b};
        o_qm = {w_q_sh, w_bm1};
        unique case (1'b1)
            w_neg: begin
                o_q  = {w_qm_sh, w_b};
                o_qm = {w_qm_sh, w_bm1};
            end
            w_zero: begin
                o_q  = {w_q_sh, {K{1'b0}}};
                o_qm = {w_qm_sh, {K{1'b1}}};
            end
            default: begin
                o_q  = {w_q_sh, w_b};
                o_qm = {w_q_sh, w_bm1};
            end
        endcase
    end

endmodule

// File: rtl/rrp_otf_conv.sv
// Serial MSDF signed-digit to two's-complement converter (Q/QM form).
// Ports: i_clk, i_rst (sync high), i_in_valid/o_in_ready/i_in_digit in,
//        o_out_valid/i_out_ready/o_out_value/o_out_err result out.
module rrp_otf_conv
    import rrp_otf_conv_pkg::*;
#(
    parameter int  RADIX = 4,
    parameter int  NDIG  = 7,
    localparam int D     = otf_d(RADIX),
    localparam int OW    = otf_ow(RADIX, NDIG)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [D-1:0]  i_in_digit,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [OW-1:0] o_out_value,
    output logic          o_out_err
);

    localparam int          CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    otf_state_e     r_state;
    logic [CW-1:0]  r_cnt;
    logic [OW-1:0]  r_q;
    logic [OW-1:0]  r_qm;
    logic           r_err;
    logic [OW-1:0]  r_value;
    logic           r_out_err;

    logic [OW-1:0]  w_q_nx;
    logic [OW-1:0]  w_qm_nx;
    logic           w_ill;

    rrp_otf_conv_step #(
        .RADIX (RADIX),
        .NDIG  (NDIG)
    ) u_step (
        .i_q       (r_q),
        .i_qm      (r_qm),
        .i_d       (i_in_digit),
        .o_q       (w_q_nx),
        .o_qm      (w_qm_nx),
        .o_illegal (w_ill)
    );

    assign o_in_ready  = (r_state == COLLECT);
    assign o_out_valid = (r_state == HOLD);
    assign o_out_value = r_value;
    assign o_out_err   = r_out_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_q       <= '0;
            r_qm      <= '1;
            r_err     <= 1'b0;
            r_value   <= '0;
            r_out_err <= 1'b0;
        end else begin
            unique case (r_state)
                COLLECT: begin
                    if (i_in_valid) begin
                        r_q   <= w_q_nx;
                        r_qm  <= w_qm_nx;
                        r_err <= r_err | w_ill;
                        if (r_cnt == LAST) begin
                            r_value   <= w_q_nx;
                            r_out_err <= r_err | w_ill;
                            r_cnt     <= '0;
                            r_state   <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // Converter state is cleared on hand-off so the next
                    // word starts from Q=0, QM=-1.
                    if (i_out_ready) begin
                        r_state <= COLLECT;
                        r_cnt   <= '0;
                        r_q     <= '0;
                        r_qm    <= '1;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_rrp_otf_conv.sv
// Directed and random checks of rrp_otf_conv.
// Main instance RADIX=4/NDIG=3, second instance RADIX=2/NDIG=6.
module tb_rrp_otf_conv;

    localparam int OWA = 7;
    localparam int DA  = 3;
    localparam int OWB = 7;
    localparam int DB  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [DA-1:0]  in_digit;
    logic           out_valid;
    logic           out_ready;
    logic [OWA-1:0] out_value;
    logic           out_err;

    logic           b_in_valid;
    logic           b_in_ready;
    logic [DB-1:0]  b_in_digit;
    logic           b_out_valid;
    logic           b_out_ready;
    logic [OWB-1:0] b_out_value;
    logic           b_out_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rrp_otf_conv #(.RADIX(4), .NDIG(3)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_digit  (in_digit),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_value (out_value),
        .o_out_err   (out_err)
    );

    rrp_otf_conv #(.RADIX(2), .NDIG(6)) dut_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (b_in_valid),
        .o_in_ready  (b_in_ready),
        .i_in_digit  (b_in_digit),
        .o_out_valid (b_out_valid),
        .i_out_ready (b_out_ready),
        .o_out_value (b_out_value),
        .o_out_err   (b_out_err)
    );

    task automatic put_digit(input int d);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL put_digit timeout: in_ready=%b required 1", in_ready);
        end else begin
            in_valid = 1'b1;
            in_digit = DA'(d);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_word(input string nm, input int exp, input bit eerr);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid: got %b required 1", nm, out_valid);
        end
        checks++;
        if (out_value !== OWA'(exp)) begin
            errors++;
            $display("FAIL %s value: got %0d required %0d",
                     nm, $signed(out_value), exp);
        end
        checks++;
        if (out_err !== eerr) begin
            errors++;
            $display("FAIL %s err: got %b required %b", nm, out_err, eerr);
        end
    endtask

    task automatic take_word(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s take: out_valid=%b in_ready=%b required 0/1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic send_word(input string nm, input int d0, input int d1,
                             input int d2, input int exp, input bit eerr);
        put_digit(d0);
        put_digit(d1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early valid: got %b required 0", nm, out_valid);
        end
        put_digit(d2);
        check_word(nm, exp, eerr);
        take_word(nm);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            out_value !== '0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b val=%0d err=%b required 1/0/0/0",
                     in_ready, out_valid, out_value, out_err);
        end
    endtask

    task automatic test_basic();
        send_word("w14", 1, -1, 2, 14, 1'b0);
        send_word("w63", 3, 3, 3, 63, 1'b0);
        send_word("wm63", -3, -3, -3, -63, 1'b0);
        send_word("wm16", -1, 0, 0, -16, 1'b0);
    endtask

    task automatic test_illegal();
        send_word("illegal", 1, -4, 0, 0, 1'b1);
        send_word("clean", 2, 1, -3, 33, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [OWA-1:0] held;
        put_digit(2);
        put_digit(-2);
        put_digit(1);
        check_word("bp", 25, 1'b0);
        held = out_value;
        in_valid = 1'b1;
        in_digit = DA'(3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_value !== held) begin
                errors++;
                $display("FAIL hold%0d: rdy=%b vld=%b val=%0d required 0/1/%0d",
                         i, in_ready, out_valid, out_value, held);
            end
        end
        in_valid = 1'b0;
        take_word("bp");
        send_word("b2b", 0, 0, 1, 1, 1'b0);
    endtask

    task automatic test_abort();
        put_digit(3);
        put_digit(-2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort: vld=%b rdy=%b required 0/1",
                     out_valid, in_ready);
        end
        send_word("w31", 2, 0, -1, 31, 1'b0);
    endtask

    task automatic test_radix2();
        int dg[6];
        int n;
        dg = '{1, -1, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            b_in_valid = 1'b1;
            b_in_digit = DB'(dg[i]);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (b_out_valid !== 1'b1 || b_out_value !== OWB'(17) ||
            b_out_err !== 1'b0) begin
            errors++;
            $display("FAIL radix2: vld=%b val=%0d err=%b required 1/17/0",
                     b_out_valid, b_out_value, b_out_err);
        end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
    endtask

    task automatic test_random();
        int exp;
        int d;
        for (int w = 0; w < 8; w++) begin
            exp = 0;
            for (int i = 0; i < 3; i++) begin
                d = int'($urandom_range(0, 6)) - 3;
                exp = exp * 4 + d;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                put_digit(d);
            end
            check_word("rand", exp, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            take_word("rand");
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_digit    = '0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_digit  = '0;
        b_out_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_illegal();
        test_back_to_back();
        test_abort();
        test_radix2();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
